// File: rtl/pong_pkg.sv
// Shared types and constants for the pong per-frame update sequencer.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  localparam int unsigned STG_INPUT  = 0;
  localparam int unsigned STG_PADDLE = 1;
  localparam int unsigned STG_BALL   = 2;
  localparam int unsigned STG_SCORE  = 3;

  localparam int unsigned DEF_TIMEOUT = 1024;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a signal arriving from another timing domain.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/sync_edge_detect.sv
// Synchronizes an input and emits a registered one-cycle pulse on its falling edge.
module sync_edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic fall_o
);

  logic       sync_s;
  logic       s3_q;
  logic       fall_q;
  logic [2:0] prime_q;

  sync_2ff #(.RESET_VAL(RESET_VAL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (d_i),
    .q_o (sync_s)
  );

  // Edges only count once every flop holds a real sample, so an input
  // already low when reset releases never looks like a fresh falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_q    <= RESET_VAL;
      fall_q  <= 1'b0;
      prime_q <= '0;
    end else begin
      s3_q    <= sync_s;
      prime_q <= {prime_q[1:0], 1'b1};
      fall_q  <= prime_q[2] & s3_q & ~sync_s;
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/pong_frame_sequencer.sv
// Runs the ordered game-update stages once per vertical sync via req/ack handshakes.
module pong_frame_sequencer
  import pong_pkg::*;
#(
  parameter int unsigned N_STAGES = 4,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
  parameter int unsigned FRAME_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vga_v_sync,
  input  logic                inDisplayArea,
  input  logic                pause,
  input  logic                clear_flags,
  input  logic [N_STAGES-1:0] stage_ack,
  output logic [N_STAGES-1:0] stage_req,
  output logic                busy,
  output logic                frame_tick,
  output logic                seq_done,
  output logic [FRAME_W-1:0]  frame_cnt,
  output logic                timeout_err,
  output logic                overrun_err,
  output logic                late_err
);

  localparam int unsigned IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_STAGES - 1);
  localparam logic [TMO_W-1:0] LAST_TMO  = TMO_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(STG_INPUT);

  logic vs_event, da_sync;

  sync_edge_detect #(.RESET_VAL(1'b1)) u_vs_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (vga_v_sync),
    .fall_o (vs_event)
  );

  sync_2ff #(.RESET_VAL(1'b0)) u_da_sync (
    .clk (clk),
    .rst (rst),
    .d_i (inDisplayArea),
    .q_o (da_sync)
  );

  seq_state_t          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                restart_q, restart_d;
  logic [N_STAGES-1:0] req_q, req_d;
  logic                busy_q, busy_d;
  logic                tick_q, tick_d;
  logic                done_q, done_d;
  logic [FRAME_W-1:0]  cnt_q, cnt_d;
  logic                tmo_err_q, tmo_err_d;
  logic                ovr_err_q, ovr_err_d;
  logic                late_err_q, late_err_d;
  logic                ack_hit, tmo_set, ovr_set, late_set;

  assign ack_hit  = |(req_q & stage_ack);
  assign late_set = da_sync & busy_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    restart_d = 1'b0;
    req_d     = req_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tick_d    = vs_event;
    cnt_d     = cnt_q + FRAME_W'(vs_event);
    tmo_set   = 1'b0;
    ovr_set   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (vs_event) begin
          // Overrun: drop req for one cycle (restart_q) before re-issuing stage 0.
          ovr_set = 1'b1;
          req_d   = '0;
          idx_d   = FIRST_IDX;
          tmo_d   = '0;
          if (pause) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            restart_d = 1'b1;
            busy_d    = 1'b1;
          end
        end else if (restart_q) begin
          req_d = N_STAGES'(1) << FIRST_IDX;
        end else if (ack_hit || (tmo_q == LAST_TMO)) begin
          tmo_set = ~ack_hit;
          tmo_d   = '0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            req_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            req_d = N_STAGES'(1) << (idx_q + IDX_W'(1));
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_IDLE, ST_DONE: begin
        req_d   = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (vs_event && !pause) begin
          state_d = ST_RUN;
          idx_d   = FIRST_IDX;
          tmo_d   = '0;
          req_d   = N_STAGES'(1) << FIRST_IDX;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
    tmo_err_d  = tmo_set  | (tmo_err_q  & ~clear_flags);
    ovr_err_d  = ovr_set  | (ovr_err_q  & ~clear_flags);
    late_err_d = late_set | (late_err_q & ~clear_flags);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      tmo_q      <= '0;
      restart_q  <= 1'b0;
      req_q      <= '0;
      busy_q     <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      tmo_err_q  <= 1'b0;
      ovr_err_q  <= 1'b0;
      late_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      restart_q  <= restart_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      tmo_err_q  <= tmo_err_d;
      ovr_err_q  <= ovr_err_d;
      late_err_q <= late_err_d;
    end
  end

  assign stage_req   = req_q;
  assign busy        = busy_q;
  assign frame_tick  = tick_q;
  assign seq_done    = done_q;
  assign frame_cnt   = cnt_q;
  assign timeout_err = tmo_err_q;
  assign overrun_err = ovr_err_q;
  assign late_err    = late_err_q;

endmodule

// File: doc/pong_frame_sequencer.md
Name: pong_frame_sequencer

Overview:
Per-frame scheduler for the pong game logic. It watches the active-low vertical sync and display-area strobe from the VGA sync generator. At each vertical-sync assertion it runs a fixed, ordered set of game-update stages (input sample, paddle move, ball move, collision/score) using a req/ack handshake per stage, so that game state only changes during vertical blanking. It reports frame count, completion, per-stage timeouts and frame overruns.

Parameters:
N_STAGES, 4, number of sequenced update stages; stage 0 is issued first.
TIMEOUT, 1024, clk cycles a stage may hold req without ack before it is abandoned; minimum 2.
FRAME_W, 16, width of the frame counter.

Ports:
clk  input  1  system clock; the same clock that drives the sync generator's pixel-clock divider
rst  input  1  asynchronous, active-high reset
vga_v_sync  input  1  vertical sync from the generator, active low
inDisplayArea  input  1  active-video strobe from the generator
pause  input  1  level; when high, frames are counted but no stages are issued
clear_flags  input  1  one-cycle pulse; clears all sticky error flags
stage_ack  input  N_STAGES  per-stage acknowledge from the game units
stage_req  output  N_STAGES  one-hot or zero; request to the current stage
busy  output  1  high while a stage sequence is in progress
frame_tick  output  1  one-cycle pulse at each detected vsync assertion
seq_done  output  1  one-cycle pulse when the last stage is acknowledged or abandoned
frame_cnt  output  FRAME_W  number of vsync assertions since reset; wraps modulo 2^FRAME_W
timeout_err  output  1  sticky; set when any stage is abandoned
overrun_err  output  1  sticky; set when a vsync arrives while the sequence is still busy
late_err  output  1  sticky; set when inDisplayArea is high while busy

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: all outputs 0.
  - FSM: state IDLE, stage index 0, timeout counter 0.
  - Synchronizers: vsync flops reset to 1 (inactive), so no edge is seen after reset; display-area flops reset to 0.
- Input synchronization:
  - vga_v_sync and inDisplayArea each pass through a 2-flop synchronizer.
  - vs_event is the high-to-low transition of the synchronized vsync, registered against a third flop.
- Latency: if vga_v_sync is first sampled low at clk edge E0, then frame_tick and stage_req[0] are both high in the cycle following edge E3. In other words, they are registered outputs of the FSM reacting to vs_event.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On vs_event: pulse frame_tick and increment frame_cnt.
  - If pause is low: stage index 0, clear the timeout counter, go to RUN.
  - If pause is high: remain in IDLE.
- RUN:
  - stage_req = one-hot of the stage index; busy = 1.
  - Any cycle in which stage_req[i] and stage_ack[i] are both high completes stage i. This includes the first cycle of req.
  - On completion, req drops the next cycle (no back-to-back reuse of the same req). The index advances and the next req rises in that same next cycle. A one-cycle req gap between stages is NOT inserted.
  - Acks on non-active stage bits are ignored.
  - Timeout: the counter increments each RUN cycle without ack. At TIMEOUT-1 with no ack, set timeout_err and treat the stage as completed (abandoned).
  - After the last stage completes: go to DONE.
- DONE: seq_done pulses for one cycle, busy = 0, stage_req = 0, then go to IDLE.
- Overrun (vs_event while in RUN):
  - Set overrun_err, pulse frame_tick, increment frame_cnt.
  - Abort the current stage: req drops for exactly one cycle.
  - Restart at stage 0 (or IDLE if pause is high).
  - seq_done is not pulsed for the aborted sequence.
- vs_event in DONE is handled exactly as in IDLE, in the same cycle.
- late_err: set on any cycle where synchronized inDisplayArea is 1 and busy is 1.
- pause rising mid-sequence does not abort; the current sequence completes.
- clear_flags clears all three sticky flags. If clear_flags coincides with a set event, the set wins.
- frame_cnt wraps from 2^FRAME_W-1 to 0 silently.

Decomposition:
- Shared package pong_pkg holds:
  - FSM state typedef (IDLE/RUN/DONE);
  - stage index localparams STG_INPUT=0, STG_PADDLE=1, STG_BALL=2, STG_SCORE=3;
  - default TIMEOUT.
- One natural sub-module, sync_edge_detect: a 2-flop synchronizer plus falling-edge pulse, instantiated for vsync. Its synchronizer part is reused for inDisplayArea.

Test Plan:
1. Reset, then drive vga_v_sync 1→0; all stages ack on their first req cycle -> frame_tick at E3, stage_req = 0001, 0010, 0100, 1000 on consecutive cycles, seq_done at E3+4 cycles, frame_cnt = 1, no flags.
2. Stage 2 never acks, TIMEOUT = 8 -> stage_req = 0100 held for exactly 8 cycles, then timeout_err = 1, stage 3 issued, seq_done pulses.
3. Stage 1 withholds ack; a second vsync fall arrives -> overrun_err = 1, frame_cnt = 2, req gap of 1 cycle, restart at stage_req = 0001, no seq_done for the first frame.
4. pause = 1 across 3 vsync falls -> frame_cnt increments 0→3, frame_tick pulses 3 times, stage_req stays 0, busy stays 0.
5. Hold acks off until inDisplayArea rises -> late_err = 1. Then pulse clear_flags with no new event -> all sticky flags 0; clear_flags coincident with a new timeout -> timeout_err stays 1.
6. Assert rst mid-RUN with stage_req = 0100 -> all outputs 0 immediately (async). After release, vsync held low produces no frame_tick until a new 1→0 transition.
